// File: rtl/maxpool2_relu.sv
// ReLU followed by a 2x2 stride-2 max-pool on three channels of a raster-order conv2 stream.
// The channels share one set of row/column counters; only the datapath is replicated.
module maxpool2_relu #(
  parameter int IN_WIDTH  = 8,
  parameter int IN_HEIGHT = 8,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out,
  output logic                 frame_done
);

  localparam int NCH   = 3;
  localparam int PAIRS = IN_WIDTH / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int RW    = $clog2(IN_HEIGHT);

  // Column is kept split as {col_pair, col_odd}, so col_pair is col>>1 directly.
  logic [PW-1:0] col_pair;
  logic          col_odd;
  logic [RW-1:0] row;

  logic last_col;
  logic last_row;
  logic row_odd;
  logic lb_write;
  logic emit;

  logic [NCH*DATA_BITS-1:0] din_flat;

  assign din_flat = {conv_in_3, conv_in_2, conv_in_1};

  assign last_col = col_odd && (col_pair == PW'(PAIRS - 1));
  assign last_row = (row == RW'(IN_HEIGHT - 1));
  assign row_odd  = row[0];
  assign lb_write = valid_in && col_odd && !row_odd;
  assign emit     = valid_in && col_odd && row_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_pair <= '0;
      col_odd  <= 1'b0;
      row      <= '0;
    end else if (valid_in) begin
      col_odd <= ~col_odd;
      if (col_odd) begin
        if (last_col) begin
          col_pair <= '0;
          row      <= last_row ? '0 : row + 1'b1;
        end else begin
          col_pair <= col_pair + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit;
      frame_done <= emit && last_col && last_row;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [DATA_BITS-1:0] din;
    logic [DATA_BITS-1:0] relu_v;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] pair;
    logic [DATA_BITS-1:0] lb_rd;
    logic [DATA_BITS-1:0] pooled;
    logic [DATA_BITS-1:0] pool_q;
    logic [DATA_BITS-1:0] lb_q [PAIRS];

    assign din    = din_flat[ch*DATA_BITS +: DATA_BITS];
    // After ReLU every value is non-negative, so plain unsigned compares suffice.
    assign relu_v = din[DATA_BITS-1] ? '0 : din;
    assign pair   = (hold_q > relu_v) ? hold_q : relu_v;
    assign lb_rd  = lb_q[col_pair];
    assign pooled = (lb_rd > pair) ? lb_rd : pair;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
      end else if (valid_in && !col_odd) begin
        hold_q <= relu_v;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PAIRS; i++) begin
          lb_q[i] <= '0;
        end
      end else if (lb_write) begin
        lb_q[col_pair] <= pair;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pool_q <= '0;
      end else if (emit) begin
        pool_q <= pooled;
      end
    end
  end

  assign pool_out_1 = g_ch[0].pool_q;
  assign pool_out_2 = g_ch[1].pool_q;
  assign pool_out_3 = g_ch[2].pool_q;

endmodule

// File: tb/tb_maxpool2_relu.sv
// Randomized bench for maxpool2_relu; a window-level pooling model builds the expected outputs.
module tb_maxpool2_relu;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NOUT = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] c1 = '0, c2 = '0, c3 = '0;
  logic [11:0] p1, p2, p3;
  logic        valid_out, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int orphan = 0;
  int acc_cyc = -1;

  typedef struct {
    logic [35:0] v;
    logic        fd;
    int          c;
  } out_t;

  out_t        got[$];
  logic [35:0] exp_q[$];
  logic [11:0] frm[3][W*H];

  maxpool2_relu #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_BITS(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .conv_in_1  (c1),
    .conv_in_2  (c2),
    .conv_in_3  (c3),
    .pool_out_1 (p1),
    .pool_out_2 (p2),
    .pool_out_3 (p3),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) got.push_back('{v: {p3, p2, p1}, fd: frame_done, c: cyc});
    else if (frame_done === 1'b1) orphan++;
  end

  // Fill frm for one frame and append its pooled results to exp_q.
  task automatic gen_frame(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int idx = r * W + c;
        int ramp = r * W + c;
        case (mode)
          0: begin
            frm[0][idx] = 12'(ramp);
            frm[1][idx] = 12'($urandom);
            frm[2][idx] = 12'($urandom);
          end
          1: begin
            frm[0][idx] = 12'hF00;
            frm[1][idx] = 12'hF00;
            frm[2][idx] = 12'hF00;
          end
          2: begin
            frm[0][idx] = 12'($urandom);
            frm[1][idx] = 12'($urandom);
            frm[2][idx] = 12'($urandom_range(300));
          end
          default: begin
            frm[0][idx] = 12'(200 - ramp);
            frm[1][idx] = 12'(50 - 3 * ramp);
            frm[2][idx] = 12'($urandom);
          end
        endcase
      end
    end
    if (mode == 2) begin
      frm[0][0] = 12'hFFB; frm[0][1] = 12'd3; frm[0][W] = 12'hFFF; frm[0][W+1] = 12'd7;
      frm[0][2] = 12'h800; frm[0][3] = 12'h7FF; frm[0][W+2] = 12'h000; frm[0][W+3] = 12'hFFF;
    end
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        logic [35:0] v = '0;
        for (int ch = 0; ch < 3; ch++) begin
          int m = 0;
          for (int d = 0; d < 4; d++) begin
            logic [11:0] x = frm[ch][(2 * pr + d / 2) * W + 2 * pc + d % 2];
            int rv = x[11] ? 0 : int'(x);
            if (rv > m) m = rv;
          end
          v[ch*12 +: 12] = 12'(m);
        end
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic drive_frame(input int gap_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        valid_in = 1'b0;
        c1 = 12'($urandom); c2 = 12'($urandom); c3 = 12'($urandom);
      end
      @(negedge clk);
      valid_in = 1'b1;
      c1 = frm[0][i]; c2 = frm[1][i]; c3 = frm[2][i];
      if (i == W + 1) acc_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if ({p3, p2, p1} !== 36'd0) begin errors++; $display("FAIL reset_out got %h want 0", {p3, p2, p1}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_ramp;
    got.delete(); exp_q.delete();
    gen_frame(0); drive_frame(0, W * H); idle(4);
    checks++; if (got.size() != NOUT) begin errors++; $display("FAIL ramp_count got %0d want %0d", got.size(), NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL ramp_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
      checks++; if (got[i].fd !== (i == NOUT - 1)) begin errors++; $display("FAIL ramp_fd[%0d] got %b", i, got[i].fd); end
    end
    if (got.size() > 0) begin
      checks++; if (got[0].c != acc_cyc) begin errors++; $display("FAIL ramp_latency got %0d want %0d", got[0].c, acc_cyc); end
      checks++; if (got[0].v[11:0] !== 12'd9) begin errors++; $display("FAIL ramp_first got %0d want 9", got[0].v[11:0]); end
      checks++; if (got[got.size()-1].v[11:0] !== 12'd63) begin errors++; $display("FAIL ramp_last got %0d want 63", got[got.size()-1].v[11:0]); end
    end
  endtask

  task automatic test_all_negative;
    got.delete(); exp_q.delete();
    gen_frame(1); drive_frame(0, W * H); idle(4);
    checks++; if (got.size() != NOUT) begin errors++; $display("FAIL neg_count got %0d want %0d", got.size(), NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL neg_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
    end
  endtask

  task automatic test_signed;
    got.delete(); exp_q.delete();
    gen_frame(2); drive_frame(0, W * H); idle(4);
    checks++; if (got.size() != NOUT) begin errors++; $display("FAIL signed_count got %0d want %0d", got.size(), NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL signed_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
    end
    if (got.size() > 1) begin
      checks++; if (got[0].v[11:0] !== 12'd7) begin errors++; $display("FAIL signed_win0 got %0d want 7", got[0].v[11:0]); end
      checks++; if (got[1].v[11:0] !== 12'd2047) begin errors++; $display("FAIL signed_win1 got %0d want 2047", got[1].v[11:0]); end
    end
  endtask

  task automatic test_gapped;
    got.delete(); exp_q.delete();
    gen_frame(0); drive_frame(40, W * H); idle(4);
    checks++; if (got.size() != NOUT) begin errors++; $display("FAIL gap_count got %0d want %0d", got.size(), NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL gap_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
      checks++; if (got[i].fd !== (i == NOUT - 1)) begin errors++; $display("FAIL gap_fd[%0d] got %b", i, got[i].fd); end
    end
  endtask

  task automatic test_back_to_back;
    int nfd = 0;
    got.delete(); exp_q.delete();
    gen_frame(0); drive_frame(0, W * H);
    gen_frame(3); drive_frame(0, W * H); idle(4);
    checks++; if (got.size() != 2 * NOUT) begin errors++; $display("FAIL b2b_count got %0d want %0d", got.size(), 2 * NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (got[i].fd === 1'b1) nfd++;
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL b2b_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
    end
    checks++; if (nfd != 2) begin errors++; $display("FAIL b2b_fd_count got %0d want 2", nfd); end
  endtask

  task automatic test_reset_mid;
    got.delete(); exp_q.delete();
    gen_frame(0); drive_frame(0, 20);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b1; c1 = 12'h7FF; c2 = 12'h7FF; c3 = 12'h7FF;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid_out); end
    checks++; if ({p3, p2, p1} !== 36'd0) begin errors++; $display("FAIL midrst_out got %h want 0", {p3, p2, p1}); end
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    idle(2);
    got.delete(); exp_q.delete();
    gen_frame(0); drive_frame(0, W * H); idle(4);
    checks++; if (got.size() != NOUT) begin errors++; $display("FAIL midrst_count got %0d want %0d", got.size(), NOUT); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++; if (got[i].v !== exp_q[i]) begin errors++; $display("FAIL midrst_val[%0d] got %h want %h", i, got[i].v, exp_q[i]); end
      checks++; if (got[i].fd !== (i == NOUT - 1)) begin errors++; $display("FAIL midrst_fd[%0d] got %b", i, got[i].fd); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_negative();
    test_signed();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    checks++; if (orphan != 0) begin errors++; $display("FAIL orphan_frame_done got %0d want 0", orphan); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
